// File: rtl/jk_bank_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jk_bank_arb_pkg                                                      |
// | Shared FSM state and JK operation encodings for the JK bank arbiter. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package jk_bank_arb_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_GRANT = 3'd1;
   localparam state_t ST_APPLY = 3'd2;
   localparam state_t ST_DONE  = 3'd3;
   localparam state_t ST_WAIT  = 3'd4;

   // Upper bit drives J, lower bit drives K.
   typedef logic [1:0] jk_op_t;

   localparam jk_op_t OP_HOLD   = 2'b00;
   localparam jk_op_t OP_RESET  = 2'b01;
   localparam jk_op_t OP_SET    = 2'b10;
   localparam jk_op_t OP_TOGGLE = 2'b11;

   function automatic logic arb_pick(input logic [1:0] req, input logic rr);
      if (req == 2'b11) return rr;
      return req[1];
   endfunction

endpackage
`default_nettype wire

// File: rtl/jk_bank_arb_jk_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jk_cell                                                              |
// | Single JK storage bit with complementary output and async clear.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module jk_cell
   import jk_bank_arb_pkg::*;
(
   input  logic clk,
   input  logic clr_n,
   input  logic j,
   input  logic k,
   output logic q,
   output logic qbar
);

   logic r_q;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_q <= 1'b0;
      end else begin
         case ({j, k})
            OP_HOLD:   r_q <= r_q;
            OP_RESET:  r_q <= 1'b0;
            OP_SET:    r_q <= 1'b1;
            OP_TOGGLE: r_q <= ~r_q;
            default:   r_q <= r_q;
         endcase
      end
   end

   assign q    = r_q;
   assign qbar = ~r_q;

endmodule
`default_nettype wire

// File: rtl/jk_bank_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | jk_bank_arb                                                          |
// | Two-requester round-robin arbiter applying JK ops to an N-bit bank.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module jk_bank_arb
   import jk_bank_arb_pkg::*;
#(
   parameter int N    = 4,
   parameter int NREQ = 2
) (
   input  logic            clk,
   input  logic            clr_n,
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      op0,
   input  logic [1:0]      op1,
   input  logic [N-1:0]    mask0,
   input  logic [N-1:0]    mask1,
   output logic [NREQ-1:0] gnt,
   output logic [NREQ-1:0] done,
   output logic            busy,
   output logic [N-1:0]    q,
   output logic [N-1:0]    qbar
);

   state_t        r_state;
   state_t        w_next;
   logic          r_win;
   logic          r_rr;
   jk_op_t        r_op;
   logic [N-1:0]  r_mask;
   logic          w_win;
   logic          w_apply;
   logic [N-1:0]  w_j;
   logic [N-1:0]  w_k;

   assign w_win   = arb_pick(req, r_rr);
   assign w_apply = (r_state == ST_APPLY);

   // State register
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (req != '0) w_next = ST_GRANT;
         ST_GRANT: w_next = ST_APPLY;
         ST_APPLY: w_next = ST_DONE;
         ST_DONE:  w_next = ST_WAIT;
         ST_WAIT:  if (!req[r_win]) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      gnt  = '0;
      done = '0;
      busy = (r_state != ST_IDLE);
      case (r_state)
         ST_GRANT: gnt[r_win]  = 1'b1;
         ST_DONE:  done[r_win] = 1'b1;
         default:  ;
      endcase
   end

   // Winner is latched on entry to GRANT; op/mask and rr update on GRANT exit.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_win  <= 1'b0;
         r_rr   <= 1'b0;
         r_op   <= OP_HOLD;
         r_mask <= '0;
      end else begin
         if (r_state == ST_IDLE && req != '0) begin
            r_win <= w_win;
         end
         if (r_state == ST_GRANT) begin
            r_op   <= r_win ? op1 : op0;
            r_mask <= r_win ? mask1 : mask0;
            r_rr   <= ~r_win;
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_bit
      assign w_j[gi] = w_apply & r_mask[gi] & r_op[1];
      assign w_k[gi] = w_apply & r_mask[gi] & r_op[0];

      jk_cell u_cell (
         .clk   (clk),
         .clr_n (clr_n),
         .j     (w_j[gi]),
         .k     (w_k[gi]),
         .q     (q[gi]),
         .qbar  (qbar[gi])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_jk_bank_arb                                                       |
// | Directed table-driven bench for jk_bank_arb.                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_jk_bank_arb;

   localparam int N = 4;

   logic         clk;
   logic         clr_n;
   logic [1:0]   req;
   logic [1:0]   op0, op1;
   logic [N-1:0] mask0, mask1;
   logic [1:0]   gnt, done;
   logic         busy;
   logic [N-1:0] q, qbar;

   int total = 0;
   int bad   = 0;
   logic [N-1:0] model_q;

   typedef struct {
      logic [1:0]   req;
      logic [1:0]   op0;
      logic [1:0]   op1;
      logic [N-1:0] mask0;
      logic [N-1:0] mask1;
      logic         win;
      logic [N-1:0] exp_q;
   } vec_t;

   vec_t tab [8];

   jk_bank_arb #(.N(N), .NREQ(2)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .req   (req),
      .op0   (op0),
      .op1   (op1),
      .mask0 (mask0),
      .mask1 (mask1),
      .gnt   (gnt),
      .done  (done),
      .busy  (busy),
      .q     (q),
      .qbar  (qbar)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // gnt/done exclusivity and one-hotness every cycle while out of reset
   always @(negedge clk) begin
      if (clr_n === 1'b1) begin
         total++;
         if ((gnt != 2'b00 && done != 2'b00) || !$onehot0(gnt) || !$onehot0(done)) begin
            bad++;
            $display("FAIL gnt_done_excl: gnt=%b done=%b", gnt, done);
         end
      end
   end

   // Entered and left at a negedge with the DUT in IDLE.
   task automatic run_txn(input vec_t v, input string tag);
      logic [1:0] eg;
      eg    = 2'b01 << v.win;
      req   = v.req;
      op0   = v.op0;
      op1   = v.op1;
      mask0 = v.mask0;
      mask1 = v.mask1;
      @(posedge clk); @(negedge clk);
      chk({tag, ".gnt"},  {30'd0, gnt},  {30'd0, eg});
      chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
      @(posedge clk); @(negedge clk);
      op0   = ~op0;
      op1   = ~op1;
      mask0 = ~mask0;
      mask1 = ~mask1;
      chk({tag, ".apply_q"}, {28'd0, q}, {28'd0, model_q});
      chk({tag, ".apply_done"}, {30'd0, done}, 32'd0);
      @(posedge clk); @(negedge clk);
      chk({tag, ".done"}, {30'd0, done}, {30'd0, eg});
      chk({tag, ".q"},    {28'd0, q},    {28'd0, v.exp_q});
      chk({tag, ".qbar"}, {28'd0, qbar}, {28'd0, ~v.exp_q});
      model_q = v.exp_q;
      req[v.win] = 1'b0;
      @(posedge clk); @(negedge clk);
      chk({tag, ".wait_busy"}, {31'd0, busy}, 32'd1);
      @(posedge clk); @(negedge clk);
      chk({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      tab[0] = '{2'b01, 2'b10, 2'b00, 4'b0101, 4'b0000, 1'b0, 4'b0101};
      tab[1] = '{2'b10, 2'b00, 2'b00, 4'b0000, 4'b1111, 1'b1, 4'b0101};
      tab[2] = '{2'b11, 2'b11, 2'b01, 4'b1111, 4'b1111, 1'b0, 4'b1010};
      tab[3] = '{2'b10, 2'b11, 2'b01, 4'b1111, 4'b1111, 1'b1, 4'b0000};
      tab[4] = '{2'b01, 2'b11, 2'b00, 4'b0000, 4'b0000, 1'b0, 4'b0000};
      tab[5] = '{2'b10, 2'b00, 2'b10, 4'b0000, 4'b1001, 1'b1, 4'b1001};
      tab[6] = '{2'b11, 2'b01, 2'b11, 4'b1000, 4'b0110, 1'b0, 4'b0001};
      tab[7] = '{2'b11, 2'b10, 2'b11, 4'b1111, 4'b0011, 1'b1, 4'b0010};

      clr_n = 1'b0;
      req   = 2'b00;
      op0   = 2'b00;
      op1   = 2'b00;
      mask0 = '0;
      mask1 = '0;
      model_q = '0;
      #2;
      chk("rst.q",    {28'd0, q},    32'h0);
      chk("rst.qbar", {28'd0, qbar}, 32'hF);
      chk("rst.gnt",  {30'd0, gnt},  32'd0);
      chk("rst.done", {30'd0, done}, 32'd0);
      chk("rst.busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      clr_n = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_txn(tab[i], $sformatf("vec%0d", i));
      end

      // Both requesters contending: grants alternate, bit 0 toggles
      for (int i = 0; i < 4; i++) begin
         vec_t v;
         v = '{2'b11, 2'b11, 2'b11, 4'b0001, 4'b0001, i[0], model_q ^ 4'b0001};
         run_txn(v, $sformatf("alt%0d", i));
      end

      // Held request must not be re-granted until it drops for a cycle
      req = 2'b01; op0 = 2'b10; mask0 = 4'b0100;
      @(posedge clk); @(negedge clk);
      chk("hold.gnt1", {30'd0, gnt}, 32'd1);
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      chk("hold.done1", {30'd0, done}, 32'd1);
      chk("hold.q1", {28'd0, q}, 32'h6);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); @(negedge clk);
         chk($sformatf("hold.wait%0d_gnt", i), {30'd0, gnt}, 32'd0);
         chk($sformatf("hold.wait%0d_busy", i), {31'd0, busy}, 32'd1);
      end
      req = 2'b00;
      @(posedge clk); @(negedge clk);
      chk("hold.idle", {31'd0, busy}, 32'd0);
      req = 2'b01;
      @(posedge clk); @(negedge clk);
      chk("hold.gnt2", {30'd0, gnt}, 32'd1);
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      chk("hold.done2", {30'd0, done}, 32'd1);
      req = 2'b00;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      model_q = 4'b0110;

      // Request dropped during GRANT still completes and WAIT exits at once
      req = 2'b10; op1 = 2'b01; mask1 = 4'b0010;
      @(posedge clk); @(negedge clk);
      chk("drop.gnt", {30'd0, gnt}, 32'd2);
      req = 2'b00;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      chk("drop.done", {30'd0, done}, 32'd2);
      chk("drop.q", {28'd0, q}, 32'h4);
      @(posedge clk); @(negedge clk);
      chk("drop.wait", {31'd0, busy}, 32'd1);
      @(posedge clk); @(negedge clk);
      chk("drop.idle", {31'd0, busy}, 32'd0);

      // Reset during APPLY aborts the operation
      req = 2'b01; op0 = 2'b10; mask0 = 4'b1111;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      clr_n = 1'b0;
      #1;
      chk("abort.q",    {28'd0, q},    32'h0);
      chk("abort.qbar", {28'd0, qbar}, 32'hF);
      chk("abort.busy", {31'd0, busy}, 32'd0);
      chk("abort.gnt",  {30'd0, gnt},  32'd0);
      req = 2'b00;
      @(posedge clk); @(negedge clk);
      clr_n = 1'b1;
      chk("abort.done", {30'd0, done}, 32'd0);
      @(posedge clk); @(negedge clk);
      chk("abort.q2",    {28'd0, q},    32'h0);
      chk("abort.busy2", {31'd0, busy}, 32'd0);
      chk("abort.done2", {30'd0, done}, 32'd0);
      model_q = '0;

      // rr restored to requester 0 by reset
      begin
         vec_t v;
         v = '{2'b11, 2'b10, 2'b10, 4'b0001, 4'b1000, 1'b0, 4'b0001};
         run_txn(v, "post_rst");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jk_bank_arb.md
JK_BANK_ARB -- requirements
Module: jk_bank_arb

Interface
REQ-001 Parameter: N, 4, number of JK storage bits in the bank (1..16).
REQ-002 Parameter: NREQ, 2, number of requesters (fixed at 2).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 clr_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  2  per-requester request; held high until matching done pulse.
REQ-006 op0, op1  input  2 each  requester JK operation: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-007 mask0, mask1  input  N each  requester bit-select; only bits with mask=1 receive the op.
REQ-008 gnt  output  2  one-hot grant; high for exactly the GRANT cycle.
REQ-009 done  output  2  one-hot completion pulse; one cycle, to the granted requester.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 q  output  N  bank contents; qbar  output  N  bitwise complement of q at all times.

Function
REQ-012 FSM states: IDLE, GRANT, APPLY, DONE, WAIT; encoded 3 bits.
REQ-013 IDLE: if req != 00, go GRANT next cycle; else stay.
REQ-014 Arbitration in IDLE: single request wins; both high -> requester indicated by round-robin pointer rr wins.
REQ-015 GRANT: gnt[w]=1; op_w and mask_w captured into internal op_r/mask_r on this edge; rr <= ~w.
REQ-016 APPLY: per bit i, j_i/k_i = op_r when mask_r[i]=1, else 00; q updates on the APPLY->DONE edge.
REQ-017 JK per bit: 00 q unchanged, 01 q=0, 10 q=1, 11 q=~q; unmasked bits never change.
REQ-018 DONE: done[w]=1 for one cycle; next state WAIT.
REQ-019 WAIT: stay until req[w]=0, then IDLE; prevents re-grant of a request already served.
REQ-020 Latency: req rise in IDLE -> gnt next cycle -> q updated 2 cycles after gnt -> done same cycle q is visible.
REQ-021 Requests arriving or changing while busy are ignored until IDLE; op/mask changes after GRANT have no effect.
REQ-022 req[w] dropping before DONE: operation still completes; done still pulses; WAIT exits immediately.
REQ-023 mask_r=0: cycle sequence unchanged, q unchanged, done still pulses.
REQ-024 gnt and done never both high; at most one bit of each high.

Reset
REQ-025 clr_n low asynchronously forces: state IDLE, q=0, qbar=all ones, gnt=00, done=00, busy=0, rr=0 (requester 0 preferred), op_r=00, mask_r=0.
REQ-026 clr_n asserted mid-operation aborts it: no done pulse; q cleared regardless of pending op.
REQ-027 After clr_n release, first evaluation of req occurs at the first posedge clk.

Structure
REQ-028 Shared package holds FSM state encodings and op encodings (OP_HOLD, OP_RESET, OP_SET, OP_TOGGLE).
REQ-029 One sub-module jk_cell (single JK bit, q/qbar, async active-low clr_n, enable-free), instantiated N times via generate.
REQ-030 FSM, arbiter and rr pointer live in jk_bank_arb; no other sub-modules.

Verification
REQ-031 Reset then req=01, op0=10, mask0=0101 -> gnt=01 next cycle, q=0101, qbar=1010, done=01 two cycles after gnt.
REQ-032 q=0101; req=11, op0=11, op1=01, mask=1111 both, rr=0 -> requester 0 first (q=1010), then requester 1 after WAIT/IDLE (q=0000); gnt order 01,10.
REQ-033 Both req held continuously, mask 0001 op toggle -> grants alternate 01,10,01,10; q[0] toggles each transaction.
REQ-034 clr_n pulsed low during APPLY with op set, mask 1111 -> q=0000, no done, state IDLE, busy=0.
REQ-035 req0 held high after done -> no second gnt until req0 low one cycle, then high again.
REQ-036 mask0=0000, op0=11 -> full gnt/done sequence, q unchanged.
